// File: rtl/s_axis_cc_arbiter.sv
// Packet-granular round-robin arbiter that merges N completer-completion streams
// onto one CC stream; a granted port keeps the stream until its tlast beat is accepted.
module s_axis_cc_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          user_clk,
  input  logic                          user_reset,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_cc_tdata,
  input  logic [N_PORTS*KEEP_WIDTH-1:0] s_axis_cc_tkeep,
  input  logic [N_PORTS-1:0]            s_axis_cc_tlast,
  input  logic [N_PORTS*4-1:0]          s_axis_cc_tuser,
  input  logic [N_PORTS-1:0]            s_axis_cc_tvalid,
  output logic [N_PORTS-1:0]            s_axis_cc_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_cc_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_cc_tkeep,
  output logic                          m_axis_cc_tlast,
  output logic [3:0]                    m_axis_cc_tuser,
  output logic                          m_axis_cc_tvalid,
  input  logic                          m_axis_cc_tready,
  output logic                          arb_busy,
  output logic [N_PORTS-1:0]            arb_grant
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W:0]     cand;
  logic               found;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Datapath mux: the granted port's slice goes straight through with no register.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path can
    // leave a signal unassigned and infer a latch.
    m_axis_cc_tdata  = '0;
    m_axis_cc_tkeep  = '0;
    m_axis_cc_tlast  = 1'b0;
    m_axis_cc_tuser  = '0;
    m_axis_cc_tvalid = 1'b0;
    s_axis_cc_tready = '0;
    arb_grant        = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_q == IDX_W'(i)) begin
        m_axis_cc_tdata = s_axis_cc_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_cc_tkeep = s_axis_cc_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_cc_tlast = s_axis_cc_tlast[i];
        m_axis_cc_tuser = s_axis_cc_tuser[i*4 +: 4];
        if (state_q == BUSY) begin
          m_axis_cc_tvalid    = s_axis_cc_tvalid[i];
          s_axis_cc_tready[i] = m_axis_cc_tready;
          arb_grant[i]        = 1'b1;
        end
      end
    end
  end

  assign arb_busy = (state_q == BUSY);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    cand         = '0;
    case (state_q)
      IDLE: begin
        // Scan last_grant+1 .. last_grant+N (mod N); first requester wins.
        for (int k = 1; k <= N_PORTS; k++) begin
          cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
          if (cand >= (IDX_W+1)'(N_PORTS)) begin
            cand = cand - (IDX_W+1)'(N_PORTS);
          end
          if (!found && s_axis_cc_tvalid[cand[IDX_W-1:0]]) begin
            found   = 1'b1;
            grant_d = cand[IDX_W-1:0];
          end
        end
        if (found) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (m_axis_cc_tvalid && m_axis_cc_tready && m_axis_cc_tlast) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          grant_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_s_axis_cc_arbiter.sv
// Directed bench for s_axis_cc_arbiter: queue-driven sources, a packet-level
// owner/last-winner reference model checked every cycle, and literal expectations per scenario.
module tb_s_axis_cc_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int KW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [3:0]    user;
  } beat_t;

  typedef struct {
    int         port;
    int         pkt;
    int         beat;
    logic       last;
    logic [3:0] user;
    int         cyc;
  } rec_t;

  logic            user_clk = 1'b0;
  logic            user_reset = 1'b1;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N*KW-1:0] s_tkeep = '0;
  logic [N-1:0]    s_tlast = '0;
  logic [N*4-1:0]  s_tuser = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic [3:0]      m_tuser;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            arb_busy;
  logic [N-1:0]    arb_grant;

  int     vectors = 0;
  int     errors  = 0;
  int     cyc     = 0;
  beat_t  q0[$];
  beat_t  q1[$];
  rec_t   log_q[$];
  logic [N-1:0] hs   = '0;
  logic [N-1:0] hold = '0;

  // Reference model state: owner = -1 when no packet is in flight.
  int owner  = -1;
  int last_w = N - 1;

  s_axis_cc_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .user_clk         (user_clk),
    .user_reset       (user_reset),
    .s_axis_cc_tdata  (s_tdata),
    .s_axis_cc_tkeep  (s_tkeep),
    .s_axis_cc_tlast  (s_tlast),
    .s_axis_cc_tuser  (s_tuser),
    .s_axis_cc_tvalid (s_tvalid),
    .s_axis_cc_tready (s_tready),
    .m_axis_cc_tdata  (m_tdata),
    .m_axis_cc_tkeep  (m_tkeep),
    .m_axis_cc_tlast  (m_tlast),
    .m_axis_cc_tuser  (m_tuser),
    .m_axis_cc_tvalid (m_tvalid),
    .m_axis_cc_tready (m_tready),
    .arb_busy         (arb_busy),
    .arb_grant        (arb_grant)
  );

  always #5 user_clk = ~user_clk;
  always @(posedge user_clk) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk(input int port, input int pkt, input int beat, input bit last);
    beat_t b;
    b.data = {8'(port), 8'(pkt), 8'(beat), 40'h5A_C3_96_E1_0F ^ 40'(beat * 7919)};
    b.keep = last ? ((port == 0) ? 8'h0F : 8'h3F) : 8'hFF;
    b.last = last;
    b.user = {(beat == 1), 2'b00, last};
    return b;
  endfunction

  task automatic push_pkt(input int port, input int pkt, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (port == 0) q0.push_back(mk(port, pkt, b, b == nbeats - 1));
      else           q1.push_back(mk(port, pkt, b, b == nbeats - 1));
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Sources: pop an accepted beat, then present the next head of queue.
  always @(posedge user_clk) begin
    #1;
    if (hs[0] && q0.size() != 0) void'(q0.pop_front());
    if (hs[1] && q1.size() != 0) void'(q1.pop_front());
    s_tvalid[0] = !user_reset && (q0.size() != 0) && !hold[0];
    s_tvalid[1] = !user_reset && (q1.size() != 0) && !hold[1];
    if (q0.size() != 0) begin
      s_tdata[0 +: DW] = q0[0].data;
      s_tkeep[0 +: KW] = q0[0].keep;
      s_tlast[0]       = q0[0].last;
      s_tuser[0 +: 4]  = q0[0].user;
    end
    if (q1.size() != 0) begin
      s_tdata[DW +: DW] = q1[0].data;
      s_tkeep[KW +: KW] = q1[0].keep;
      s_tlast[1]        = q1[0].last;
      s_tuser[4 +: 4]   = q1[0].user;
    end
  end

  // Compare process: checks DUT outputs against the model on every falling edge.
  always @(negedge user_clk) begin
    logic [N-1:0] exp_rdy;
    hs = s_tvalid & s_tready;
    if (!user_reset && m_tvalid && m_tready) begin
      log_q.push_back('{int'(m_tdata[63:56]), int'(m_tdata[55:48]), int'(m_tdata[47:40]),
                        m_tlast, m_tuser, cyc});
    end
    if (user_reset) begin
      check("rst tvalid", m_tvalid, 0);
      check("rst tready", s_tready, 0);
      check("rst grant", arb_grant, 0);
      check("rst busy", arb_busy, 0);
      owner  = -1;
      last_w = N - 1;
    end else if (owner < 0) begin
      check("idle tvalid", m_tvalid, 0);
      check("idle tready", s_tready, 0);
      check("idle grant", arb_grant, 0);
      check("idle busy", arb_busy, 0);
      owner = rr_pick(last_w, s_tvalid);
    end else begin
      exp_rdy = '0;
      exp_rdy[owner] = m_tready;
      check("busy tvalid", m_tvalid, s_tvalid[owner]);
      check("busy tready", s_tready, exp_rdy);
      check("busy grant", arb_grant, N'(1) << owner);
      check("busy flag", arb_busy, 1);
      if (s_tvalid[owner]) begin
        check("busy tdata", m_tdata, s_tdata[owner*DW +: DW]);
        check("busy tkeep", m_tkeep, s_tkeep[owner*KW +: KW]);
        check("busy tlast", m_tlast, s_tlast[owner]);
        check("busy tuser", m_tuser, s_tuser[owner*4 +: 4]);
        if (m_tready && s_tlast[owner]) begin
          last_w = owner;
          owner  = -1;
        end
      end
    end
  end

  task automatic nstep();
    @(negedge user_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge user_clk);
    #1;
    user_reset = 1'b1;
    q0.delete();
    q1.delete();
    hold = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge user_clk);
    #1;
    user_reset = 1'b0;
    log_q.delete();
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      nstep();
      done = (q0.size() == 0) && (q1.size() == 0) && !arb_busy && (s_tvalid == '0);
    end
    check({name, " completion"}, done, 1);
  endtask

  task automatic wait_log(input string name, input int n);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      nstep();
      done = (log_q.size() >= n);
    end
    check({name, " log wait"}, done, 1);
  endtask

  task automatic check_order(input string name, input int ports[], input int beats[]);
    check({name, " count"}, log_q.size(), ports.size());
    for (int i = 0; i < ports.size() && i < log_q.size(); i++) begin
      check($sformatf("%s port[%0d]", name, i), log_q[i].port, ports[i]);
      check($sformatf("%s beat[%0d]", name, i), log_q[i].beat, beats[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[4];
    int expb[4];
    pat  = '{1, 0, 0, 1};
    expb = '{0, 1, 1, 1};

    // T1: single 3-beat packet from port 0, discontinue on beat 1.
    do_reset();
    nstep();
    check("t1 reset busy", arb_busy, 0);
    check("t1 reset grant", arb_grant, 0);
    push_pkt(0, 1, 3);
    nstep();
    check("t1 bubble tvalid", m_tvalid, 0);
    check("t1 bubble tready", s_tready, 0);
    nstep();
    check("t1 first tvalid", m_tvalid, 1);
    check("t1 first grant", arb_grant, 2'b01);
    check("t1 first tdata", m_tdata, 64'h00_01_00_5AC396E10F);
    wait_done("t1");
    check_order("t1", '{0, 0, 0}, '{0, 1, 2});
    if (log_q.size() == 3) begin
      check("t1 contiguous", log_q[2].cyc - log_q[0].cyc, 2);
      check("t1 discontinue passes", log_q[1].user, 4'b1000);
      check("t1 mid not last", log_q[1].last, 0);
      check("t1 tlast", log_q[2].last, 1);
      check("t1 last user", log_q[2].user, 4'b0001);
    end
    check("t1 grant after", arb_grant, 0);

    // T2: both ports request together from reset, 2 beats each.
    do_reset();
    nstep();
    push_pkt(0, 2, 2);
    push_pkt(1, 2, 2);
    wait_done("t2");
    check_order("t2", '{0, 0, 1, 1}, '{0, 1, 0, 1});
    if (log_q.size() == 4) begin
      check("t2 one bubble", log_q[2].cyc - log_q[1].cyc, 2);
      check("t2 p1 contiguous", log_q[3].cyc - log_q[2].cyc, 1);
    end

    // T3: 4 single-beat packets per port, alternating at one packet per 2 cycles.
    do_reset();
    nstep();
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, 10 + k, 1);
      push_pkt(1, 10 + k, 1);
    end
    wait_done("t3");
    check_order("t3", '{0, 1, 0, 1, 0, 1, 0, 1}, '{0, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 1; i < log_q.size(); i++) begin
      check($sformatf("t3 spacing[%0d]", i), log_q[i].cyc - log_q[i-1].cyc, 2);
    end

    // T4: port 1 in flight with output stalls while port 0 waits.
    do_reset();
    m_tready = 1'b0;
    nstep();
    push_pkt(1, 20, 4);
    nstep();
    nstep();
    check("t4 grant p1", arb_grant, 2'b10);
    push_pkt(0, 21, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge user_clk);
      #1;
      m_tready = pat[k][0];
      nstep();
      check($sformatf("t4 p0 blocked[%0d]", k), s_tready[0], 0);
      check($sformatf("t4 held data[%0d]", k), m_tdata, mk(1, 20, expb[k], 0).data);
    end
    check("t4 beats during pattern", log_q.size(), 2);
    @(posedge user_clk);
    #1;
    m_tready = 1'b1;
    wait_done("t4");
    check_order("t4", '{1, 1, 1, 1, 0}, '{0, 1, 2, 3, 0});

    // T5: granted port drops tvalid for 3 cycles mid-packet.
    do_reset();
    nstep();
    push_pkt(0, 30, 4);
    wait_log("t5", 2);
    hold[0] = 1'b1;
    push_pkt(1, 31, 1);
    for (int k = 0; k < 3; k++) begin
      nstep();
      check($sformatf("t5 gap tvalid[%0d]", k), m_tvalid, 0);
      check($sformatf("t5 gap grant[%0d]", k), arb_grant, 2'b01);
      check($sformatf("t5 gap p1 ready[%0d]", k), s_tready[1], 0);
    end
    hold[0] = 1'b0;
    wait_done("t5");
    check_order("t5", '{0, 0, 0, 0, 1}, '{0, 1, 2, 3, 0});
    if (log_q.size() >= 3) check("t5 resume gap", log_q[2].cyc - log_q[1].cyc, 4);

    // T6: asynchronous reset mid-packet, then port 0 wins the first arbitration.
    do_reset();
    nstep();
    push_pkt(1, 40, 4);
    wait_log("t6", 1);
    check("t6 p1 granted", arb_grant, 2'b10);
    @(posedge user_clk);
    #3;
    user_reset = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check("t6 async tready", s_tready, 0);
    check("t6 async tvalid", m_tvalid, 0);
    check("t6 async grant", arb_grant, 0);
    check("t6 async busy", arb_busy, 0);
    repeat (2) @(posedge user_clk);
    #1;
    user_reset = 1'b0;
    log_q.delete();
    nstep();
    push_pkt(0, 41, 1);
    push_pkt(1, 42, 1);
    wait_done("t6");
    check_order("t6", '{0, 1}, '{0, 0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
